tx_test_src: RTL and testbench

Parametrised traffic source for bring-up and loopback testing of the 10G MAC transmit path. It sits between the MAC receive output (or an internal pattern generator) and the transmit payload FIFO write port. It writes payload words into the FIFO, tracks how many complete frames are queued, and issues single-cycle `tx_start` pulses to the TX framer whenever a frame is queued and the framer is idle. Modes:

- Loopback: re-send received frames.
- Continuous pattern: back-to-back generated frames.
- Periodic pattern: one generated frame every `period` cycles.

---
 rtl/tx_test_src.sv | 177 +++++++++++++++++
 tb/tb_tx_test_src.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_test_src.sv
// Traffic source for the 10G TX path: loopback or generated frames into the payload FIFO, one tx_start per queued frame.
// Build option TX_TEST_SRC_STATS_EN adds stat_frames / stat_ovf outputs.
module tx_test_src #(
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 16,
  parameter int CNT_W    = 24,
  parameter int PERIOD_W = 24
) (
  input  logic                wrclk_sig,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [PERIOD_W-1:0] period,
  output logic [LEN_W-1:0]    data_length,
  output logic                tx_start,
  input  logic                tx_idle,
  input  logic                rx_finish,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_wr_req,
  input  logic                wrfull,
`ifdef TX_TEST_SRC_STATS_EN
  output logic [31:0]         stat_frames,
  output logic                stat_ovf,
`endif
  output logic [DATA_W-1:0]   data_sig,
  output logic                wrreq_sig
);

  localparam int BYTES  = DATA_W / 8;
  localparam int HALF_W = DATA_W / 2;
  localparam logic [LEN_W-1:0] LOOP_LEN = LEN_W'(1448);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {GEN_IDLE, GEN_WORDS} gen_state_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_IDLE} start_state_e;

  gen_state_e          gen_q;
  logic [LEN_W-1:0]    idx_q, last_q, len_q;
  logic [HALF_W-1:0]   seq_q;
  logic [PERIOD_W-1:0] timer_q;
  logic [DATA_W-1:0]   data_q;
  logic                wrreq_q;
  logic [CNT_W-1:0]    credit_q, credit_d;
  start_state_e        start_q;
  logic [3:0]          wait_q;
  logic                tx_start_q;

  logic [LEN_W:0]      words;
  logic [LEN_W-1:0]    last_d;
  logic [PERIOD_W-1:0] reload;
  logic                timer_exp, gen_start, gen_write, gen_done, loop_act;
  logic                cr_inc, cr_dec, cr_drop;

  assign words     = ({1'b0, cfg_len} + (LEN_W+1)'(BYTES - 1)) / (LEN_W+1)'(BYTES);
  assign last_d    = (words == '0) ? '0 : LEN_W'(words - 1'b1);
  assign reload    = (period == '0) ? '0 : period - 1'b1;
  assign timer_exp = (timer_q == '0);
  assign gen_start = (gen_q == GEN_IDLE) && ((mode == 2'd1) || ((mode == 2'd2) && timer_exp));
  assign gen_write = (gen_q == GEN_WORDS) && !wrfull;
  assign gen_done  = gen_write && (idx_q == last_q);
  assign loop_act  = (gen_q == GEN_IDLE) && (mode == 2'd0);
  assign cr_inc    = gen_done || (loop_act && rx_finish);
  assign cr_dec    = tx_start_q && (credit_q != '0);
  assign cr_drop   = cr_inc && !cr_dec && (credit_q == CNT_MAX);

  always_comb begin
    credit_d = credit_q;
    if (cr_inc && !cr_dec && !cr_drop) begin
      credit_d = credit_q + 1'b1;
    end else if (cr_dec && !cr_inc) begin
      credit_d = credit_q - 1'b1;
    end
  end

  // A frame in progress owns the write port; mode is only acted on from GEN_IDLE.
  always_ff @(posedge wrclk_sig or negedge rst_n) begin
    if (!rst_n) begin
      gen_q   <= GEN_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      seq_q   <= '0;
      timer_q <= '0;
      len_q   <= LOOP_LEN;
      data_q  <= '0;
      wrreq_q <= 1'b0;
    end else begin
      timer_q <= (mode != 2'd2) ? '0 : (timer_exp ? reload : timer_q - 1'b1);
      wrreq_q <= 1'b0;
      case (gen_q)
        GEN_IDLE: begin
          if (loop_act) begin
            wrreq_q <= rx_wr_req;
            data_q  <= rx_data;
            len_q   <= LOOP_LEN;
          end else if (gen_start) begin
            gen_q  <= GEN_WORDS;
            idx_q  <= '0;
            last_q <= last_d;
            len_q  <= cfg_len;
          end
        end
        default: begin
          if (gen_write) begin
            wrreq_q <= 1'b1;
            data_q  <= {seq_q, HALF_W'(idx_q)};
            idx_q   <= idx_q + 1'b1;
            if (gen_done) begin
              seq_q <= seq_q + 1'b1;
              gen_q <= GEN_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Credit drops when the pulse is on the wire, so the pulse cycle still sees the old count.
  always_ff @(posedge wrclk_sig or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= S_IDLE;
      wait_q     <= '0;
      tx_start_q <= 1'b0;
      credit_q   <= '0;
    end else begin
      credit_q   <= credit_d;
      tx_start_q <= 1'b0;
      case (start_q)
        S_IDLE: begin
          if ((credit_q != '0) && tx_idle) begin
            tx_start_q <= 1'b1;
            wait_q     <= '0;
            start_q    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!tx_idle) begin
            start_q <= S_WAIT_IDLE;
          end else if (wait_q == 4'd15) begin
            start_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (tx_idle) start_q <= S_IDLE;
        end
        default: start_q <= S_IDLE;
      endcase
    end
  end

`ifdef TX_TEST_SRC_STATS_EN
  logic [31:0] frames_q;
  logic        ovf_q;

  always_ff @(posedge wrclk_sig or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (tx_start_q) frames_q <= frames_q + 1'b1;
      if (cr_drop)    ovf_q    <= 1'b1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_ovf    = ovf_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign data_length = len_q;
  assign tx_start    = tx_start_q;
  assign data_sig    = data_q;
  assign wrreq_sig   = wrreq_q;

endmodule

// File: tb/tb_tx_test_src.sv
// Directed bench for tx_test_src: reset, loopback, continuous with stall, periodic, simultaneous credit events, lost start.
module tb_tx_test_src;
  logic        wrclk_sig;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] cfg_len;
  logic [23:0] period;
  logic [15:0] data_length;
  logic        tx_start;
  logic        tx_idle;
  logic        rx_finish;
  logic [63:0] rx_data;
  logic        rx_wr_req;
  logic        wrfull;
  logic [63:0] data_sig;
  logic        wrreq_sig;
`ifdef TX_TEST_SRC_STATS_EN
  logic [31:0] stat_frames;
  logic        stat_ovf;
`endif

  tx_test_src dut (
    .wrclk_sig   (wrclk_sig),
    .rst_n       (rst_n),
    .mode        (mode),
    .cfg_len     (cfg_len),
    .period      (period),
    .data_length (data_length),
    .tx_start    (tx_start),
    .tx_idle     (tx_idle),
    .rx_finish   (rx_finish),
    .rx_data     (rx_data),
    .rx_wr_req   (rx_wr_req),
    .wrfull      (wrfull),
`ifdef TX_TEST_SRC_STATS_EN
    .stat_frames (stat_frames),
    .stat_ovf    (stat_ovf),
`endif
    .data_sig    (data_sig),
    .wrreq_sig   (wrreq_sig)
  );

  initial wrclk_sig = 1'b0;
  always #5 wrclk_sig = ~wrclk_sig;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_start = 0;
  int busy_cnt = 0;
  int busy_len = 5;
  logic fr_en = 1'b0;
  logic [63:0] wq[$];
  int wcyc[$];
  int scq[$];
  int nf;
  int s0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; also models the framer (busy for busy_len cycles after seeing tx_start) and logs writes/pulses.
  task automatic tick();
    logic pend;
    pend = tx_start;
    @(posedge wrclk_sig);
    #1;
    cyc++;
    if (fr_en && pend) begin
      busy_cnt = busy_len;
      tx_idle  = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_idle = 1'b1;
    end
    if (tx_start) begin
      n_start++;
      scq.push_back(cyc);
    end
    if (wrreq_sig) begin
      wq.push_back(data_sig);
      wcyc.push_back(cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd3; cfg_len = 16'd8; period = 24'd1;
    tx_idle = 1'b1; rx_finish = 1'b0; rx_data = '0; rx_wr_req = 1'b0; wrfull = 1'b0;
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_wrreq", wrreq_sig, 0);
    chk("rst_data", data_sig, 0);
    @(posedge wrclk_sig); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("off_no_writes", wq.size(), 0);
    chk("off_no_starts", n_start, 0);

    // Loopback: 181 words, wrfull asserted for the tail to show it is ignored.
    mode = 2'd0; fr_en = 1'b1;
    for (int i = 0; i < 181; i++) begin
      logic [63:0] d;
      d = {32'(i), 32'hA5A50000 ^ 32'(i)};
      rx_wr_req = 1'b1; rx_data = d; wrfull = (i >= 100);
      tick();
      chk("lb_wrreq", wrreq_sig, 1);
      chk("lb_data", data_sig, d);
    end
    rx_wr_req = 1'b0; wrfull = 1'b0;
    tick();
    chk("lb_wrreq_end", wrreq_sig, 0);
    s0 = n_start;
    rx_finish = 1'b1;
    tick();
    rx_finish = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    chk("lb_one_start", n_start - s0, 1);
    chk("lb_credit_zero", dut.credit_q, 0);
    chk("lb_len", data_length, 1448);

    // Continuous, 20 bytes -> 3 words/frame, 5-cycle stall after the first word.
    wq.delete(); wcyc.delete();
    s0 = n_start;
    cfg_len = 16'd20; mode = 2'd1;
    for (int k = 0; k < 50 && wq.size() == 0; k++) tick();
    chk("cont_first_word", wq.size(), 1);
    wrfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("cont_stall_nowr", wrreq_sig, 0);
    end
    wrfull = 1'b0;
    for (int k = 0; k < 100 && wq.size() < 9; k++) tick();
    mode = 2'd3;
    for (int k = 0; k < 60; k++) tick();
    chk("cont_whole_frames", wq.size() % 3, 0);
    for (int i = 0; i < 9; i++) chk("cont_word", wq[i], {32'(i / 3), 32'(i % 3)});
    nf = wq.size() / 3;
    chk("cont_starts", n_start - s0, nf);
    chk("cont_credit_zero", dut.credit_q, 0);
    chk("cont_len", data_length, 20);

    // Periodic, single-word frames 100 cycles apart; sequence continues from nf.
    wq.delete(); wcyc.delete();
    cfg_len = 16'd8; period = 24'd100; mode = 2'd2;
    for (int k = 0; k < 400 && wq.size() < 3; k++) tick();
    mode = 2'd3;
    chk("per_count", wq.size(), 3);
    chk("per_gap1", wcyc[1] - wcyc[0], 100);
    chk("per_gap2", wcyc[2] - wcyc[1], 100);
    chk("per_word0", wq[0], {32'(nf), 32'd0});
    chk("per_word2", wq[2], {32'(nf + 2), 32'd0});
    chk("per_len", data_length, 8);
    for (int k = 0; k < 30; k++) tick();

    // rx_finish coinciding with the tx_start pulse while credit is 1.
    mode = 2'd0;
    rx_finish = 1'b1;
    tick();
    rx_finish = 1'b0;
    for (int k = 0; k < 10 && !tx_start; k++) tick();
    chk("sim_pulse", tx_start, 1);
    s0 = n_start;
    rx_finish = 1'b1;
    tick();
    rx_finish = 1'b0;
    chk("sim_credit_hold", dut.credit_q, 1);
    for (int k = 0; k < 30; k++) tick();
    chk("sim_second_pulse", n_start - s0, 1);
    chk("sim_credit_zero", dut.credit_q, 0);
    chk("sim_len_loop", data_length, 1448);

    // Lost start: framer never goes busy; 16 wait cycles, S_IDLE cycle, then the next pulse.
    fr_en = 1'b0; busy_cnt = 0; tx_idle = 1'b1;
    scq.delete();
    rx_finish = 1'b1;
    tick();
    tick();
    rx_finish = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    chk("lost_pulses", scq.size(), 2);
    chk("lost_gap", scq[1] - scq[0], 17);
    chk("lost_credit_zero", dut.credit_q, 0);
`ifdef TX_TEST_SRC_STATS_EN
    chk("stat_frames", stat_frames, n_start);
    chk("stat_ovf", stat_ovf, 0);
`endif

    // Asynchronous reset in the middle of a 3-word frame.
    fr_en = 1'b1; cfg_len = 16'd24; mode = 2'd1;
    wq.delete();
    for (int k = 0; k < 20 && wq.size() < 2; k++) tick();
    chk("mid_wrreq_before", wrreq_sig, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wrreq", wrreq_sig, 0);
    chk("mid_rst_data", data_sig, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    @(posedge wrclk_sig); #1;
    busy_cnt = 0; tx_idle = 1'b1;
    rst_n = 1'b1;
    wq.delete();
    for (int k = 0; k < 20 && wq.size() < 1; k++) tick();
    chk("post_rst_count", wq.size() >= 1, 1);
    chk("post_rst_word", wq[0], 64'd0);
    mode = 2'd3;
    for (int k = 0; k < 10; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
